// File: rtl/color_classifier.sv
// Windowed RGB color classifier: averages 2^AVG_LOG2 samples, classifies against percent-of-clear thresholds.
// Optional commit debounce is enabled by defining COLOR_CLS_DEBOUNCE_EN.
module color_classifier #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DOM_PCT    = 70,
  parameter int unsigned CLEAR_MIN  = 48,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] clear_data,
  input  logic [DW-1:0] red_data,
  input  logic [DW-1:0] green_data,
  input  logic [DW-1:0] blue_data,
  output logic          out_valid,
  output logic [2:0]    class_code,
  output logic          RED,
  output logic          GREEN,
  output logic          BLUE,
  output logic          WHITE
);

  localparam int unsigned AW       = DW + AVG_LOG2;
  localparam int unsigned PW       = DW + 7;
  localparam int unsigned CW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned WIN_LAST = (1 << AVG_LOG2) - 1;

  localparam logic [2:0] CLS_DARK  = 3'd0;
  localparam logic [2:0] CLS_RED   = 3'd1;
  localparam logic [2:0] CLS_GREEN = 3'd2;
  localparam logic [2:0] CLS_BLUE  = 3'd3;
  localparam logic [2:0] CLS_WHITE = 3'd4;

  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("color_classifier: STABLE_CNT must be at least 1");
  end

  typedef enum logic {ST_ACC, ST_CLS} state_t;

  state_t        state_q, state_d;
  logic          accept_c;
  logic          cls_fire_c;
  logic          commit_c;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] acc_c_q, acc_r_q, acc_g_q, acc_b_q;
  logic [DW-1:0] avg_c, avg_r, avg_g, avg_b;
  logic [PW-1:0] thr;
  logic [2:0]    res_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // Next state, acceptance and classify strobe; clr wins over everything
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    cls_fire_c = 1'b0;
    case (state_q)
      ST_ACC: begin
        accept_c = in_valid && in_ready && !clr;
        if (accept_c && (cnt_q == CW'(WIN_LAST))) state_d = ST_CLS;
      end
      ST_CLS: begin
        cls_fire_c = !clr;
        state_d    = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
    if (clr) state_d = ST_ACC;
  end

  // Window accumulators and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_c_q <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
    end else if (clr || (state_q == ST_CLS)) begin
      cnt_q   <= '0;
      acc_c_q <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
    end else if (accept_c) begin
      cnt_q   <= (cnt_q == CW'(WIN_LAST)) ? '0 : cnt_q + CW'(1);
      acc_c_q <= acc_c_q + AW'(clear_data);
      acc_r_q <= acc_r_q + AW'(red_data);
      acc_g_q <= acc_g_q + AW'(green_data);
      acc_b_q <= acc_b_q + AW'(blue_data);
    end
  end

  function automatic logic dominant(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                    input logic [DW-1:0] z, input logic [PW-1:0] t);
    return ((PW'(x) * PW'(100)) >= t) && (x > y) && (x > z);
  endfunction

  // Divider-free classification of the window average: x*100 >= DOM_PCT*(c+1)
  always_comb begin
    avg_c = DW'(acc_c_q >> AVG_LOG2);
    avg_r = DW'(acc_r_q >> AVG_LOG2);
    avg_g = DW'(acc_g_q >> AVG_LOG2);
    avg_b = DW'(acc_b_q >> AVG_LOG2);
    thr   = PW'(DOM_PCT) * (PW'(avg_c) + PW'(1));
    res_c = CLS_WHITE;
    if (PW'(avg_c) < PW'(CLEAR_MIN))          res_c = CLS_DARK;
    else if (dominant(avg_r, avg_g, avg_b, thr)) res_c = CLS_RED;
    else if (dominant(avg_g, avg_r, avg_b, thr)) res_c = CLS_GREEN;
    else if (dominant(avg_b, avg_r, avg_g, thr)) res_c = CLS_BLUE;
  end

`ifdef COLOR_CLS_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(STABLE_CNT + 1);

  logic [2:0]     cand_q, cand_d;
  logic [DBW-1:0] dcnt_q, dcnt_d;

  // Candidate tracking with a saturating agreement count
  always_comb begin
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    if (res_c == cand_q) begin
      if (dcnt_q != DBW'(STABLE_CNT)) dcnt_d = dcnt_q + DBW'(1);
    end else begin
      cand_d = res_c;
      dcnt_d = DBW'(1);
    end
    commit_c = cls_fire_c && (dcnt_d == DBW'(STABLE_CNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= CLS_DARK;
      dcnt_q <= '0;
    end else if (clr) begin
      cand_q <= CLS_DARK;
      dcnt_q <= '0;
    end else if (cls_fire_c) begin
      cand_q <= cand_d;
      dcnt_q <= dcnt_d;
    end
  end
`else
  always_comb commit_c = cls_fire_c;
`endif

  // Registered outputs; committed class is held across clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      class_code <= CLS_DARK;
      RED        <= 1'b0;
      GREEN      <= 1'b0;
      BLUE       <= 1'b0;
      WHITE      <= 1'b0;
    end else begin
      in_ready  <= (state_d == ST_ACC);
      out_valid <= cls_fire_c;
      if (commit_c) begin
        class_code <= res_c;
        RED        <= (res_c == CLS_RED);
        GREEN      <= (res_c == CLS_GREEN);
        BLUE       <= (res_c == CLS_BLUE);
        WHITE      <= (res_c == CLS_WHITE);
      end
    end
  end

endmodule

// File: doc/color_classifier.md
# color_classifier

Windowed, threshold-based RGB color classifier that sits between the color-sensor reader (which supplies clear/red/green/blue counts) and the indicator/LED logic. It averages a configurable number of sensor samples, classifies the averaged sample against percent-of-clear thresholds without any divider, and optionally debounces the decision before committing it to registered one-hot outputs. It generalises the earlier fixed 16-bit, single-sample classifier with these additions:

- parameterised data width
- sample averaging
- a dark class
- a ready/valid input handshake
- a selectable stability filter

## Interface
- DW, 16: width of each sensor channel.
- AVG_LOG2, 2: window length is 2^AVG_LOG2 samples (0 = no averaging).
- DOM_PCT, 70: dominance threshold, percent of clear, range 1–100.
- CLEAR_MIN, 48: minimum averaged clear value; below it the class is DARK.
- STABLE_CNT, 3: number of consecutive identical window results needed to commit (range ≥1; used only with the debounce macro).

Ports (reset rst_n is asynchronous, active-low; clock is clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: discards the partial window and the debounce state.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample.
- clear_data, red_data, green_data, blue_data  in  DW each  sensor channels.
- out_valid  out  1  one-cycle pulse per completed window.
- class_code  out  3  committed class: 0 DARK, 1 RED, 2 GREEN, 3 BLUE, 4 WHITE.
- RED, GREEN, BLUE, WHITE  out  1 each  one-hot decode of class_code; all 0 for DARK.

## Operation
- **FSM states:** ACC and CLS.
- **ACC state:**
  - in_ready=1.
  - A sample is accepted when in_valid and in_ready are both high.
  - On acceptance, each channel is added into its own DW+AVG_LOG2-bit accumulator, so the accumulators cannot overflow.
  - An AVG_LOG2-bit counter tracks accepted samples.
  - The accepted sample that completes the window moves the FSM to CLS.
- **CLS state (one cycle):**
  - in_ready=0.
  - Averages are computed as accumulator >> AVG_LOG2 (truncating).
  - The result is classified, the accumulators and counter are zeroed, and the FSM returns to ACC.
- **Classification** (c, r, g, b are the averages; first match wins):
  - c < CLEAR_MIN → DARK.
  - r*100 ≥ DOM_PCT*(c+1), r > g and r > b → RED.
  - Same rule with g → GREEN.
  - Same rule with b → BLUE.
  - Otherwise → WHITE.
- **Arithmetic:** products use DW+7-bit unsigned operands; no division is used.
- **Commit:**
  - The result is committed in CLS, directly or through the debounce filter (see Configuration).
  - out_valid pulses once per CLS, whether or not the committed class changes.
- **clr:**
  - Zeroes the accumulators, the counter and the debounce state, and forces the FSM to ACC.
  - Committed outputs are held.
  - clr has priority over a simultaneous sample acceptance; that sample is dropped.
  - A clr asserted during CLS cancels that cycle's commit and out_valid.
- **Reset:**
  - in_ready=1, out_valid=0, class_code=0, RED/GREEN/BLUE/WHITE=0.
  - FSM=ACC, accumulators=0, debounce candidate=0, debounce count=0.
  - Reset asserted mid-window discards the window.

## Timing
- Sample k is accepted on the rising edge where in_valid=in_ready=1.
- **Latency:**
  - The edge accepting the final window sample enters CLS.
  - On the next edge, class_code, the one-hot outputs and out_valid=1 register.
  - out_valid drops on the following edge unless another CLS occurs, which cannot happen within 2^AVG_LOG2 cycles.
- **Throughput:** one window per 2^AVG_LOG2+1 cycles when in_valid is held high; in_ready is low only during CLS.
- in_valid may be deasserted at any time with no penalty; the window simply stalls.
- Outputs are registered and stable between commits.

## Configuration
- **COLOR_CLS_DEBOUNCE_EN defined:**
  - A candidate class and a saturating count (range 0..STABLE_CNT) are kept.
  - On each CLS, if the result equals the candidate, the count is incremented (saturating). Otherwise, the candidate becomes the result and the count becomes 1.
  - class_code updates only on a CLS where the count equals STABLE_CNT after the update.
- **COLOR_CLS_DEBOUNCE_EN undefined:**
  - Every CLS result is committed directly.
  - The STABLE_CNT parameter is ignored.

## Test plan
Defaults apply unless noted; AVG_LOG2=2 (4 samples per window).

- **Dominant red:** 4 samples of C=1000, R=800, G=100, B=50 → RED=1 and class_code=1 one edge after CLS, with out_valid pulsing exactly 1 cycle. With debounce, commit occurs only after the 3rd window; out_valid pulses on every window.
- **Averaging boundary:** R alternating 900/500 with C=1000 and G=B=100 (average 700; 70000 < 70070) → WHITE. R alternating 902/500 (average 701; 70100 ≥ 70070) → RED.
- **Dark and white:** C=0x20 with any RGB → class_code=0 and all one-hot outputs 0. C=1000 with R=G=B=330 → WHITE=1, class_code=4.
- **Handshake:** in_valid toggled every other cycle → 4 acceptances per window, in_ready=0 only in the CLS cycle, and the classification matches a continuous stream.
- **clr and reset:**
  - clr after 2 samples, then 4 green samples (C=1000, G=900, R=B=50) → the first out_valid follows the 4 post-clr samples, class_code=2.
  - rst_n asserted mid-window → all outputs return to reset values immediately.
- **Debounce (macro on):** window results RED, RED, BLUE, RED, RED, RED → class_code stays 0 until the 6th window, then becomes 1; out_valid pulses 6 times.
